// File: rtl/id_stage_pipe_if.sv
// Bundle of decode-stage signals: IF/ID inputs, write-back, hazard info and the ID/EXE register.
// The slave modport is the decode stage; the master modport is the surrounding pipeline.
interface id_stage_pipe_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_CNT = 16
);
    localparam int unsigned RA_W = $clog2(REG_CNT);

    logic [31:0]       instr_in;
    logic [DATA_W-1:0] pc_in;
    logic              valid_in;
    logic [3:0]        status_in;
    logic              flush_in;
    logic              wb_en_in;
    logic [RA_W-1:0]   wb_dest_in;
    logic [DATA_W-1:0] wb_value_in;
    logic [RA_W-1:0]   exe_dest;
    logic [RA_W-1:0]   mem_dest;
    logic              exe_wb_en;
    logic              mem_wb_en;
    logic              exe_mem_r_en;

    logic              stall_out;
    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] val_rn_out;
    logic [DATA_W-1:0] val_rm_out;
    logic [RA_W-1:0]   src1_out;
    logic [RA_W-1:0]   src2_out;
    logic [RA_W-1:0]   dest_out;
    logic [3:0]        exe_cmd_out;
    logic              mem_r_en_out;
    logic              mem_w_en_out;
    logic              wb_en_out;
    logic              b_out;
    logic              s_out;
    logic              imm_out;
    logic              valid_out;
    logic [11:0]       shift_op_out;
    logic [23:0]       simm24_out;

    modport master (
        output instr_in, pc_in, valid_in, status_in, flush_in,
        output wb_en_in, wb_dest_in, wb_value_in,
        output exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_r_en,
        input  stall_out, pc_out, val_rn_out, val_rm_out, src1_out, src2_out, dest_out,
        input  exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out,
        input  valid_out, shift_op_out, simm24_out
    );

    modport slave (
        input  instr_in, pc_in, valid_in, status_in, flush_in,
        input  wb_en_in, wb_dest_in, wb_value_in,
        input  exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_r_en,
        output stall_out, pc_out, val_rn_out, val_rm_out, src1_out, src2_out, dest_out,
        output exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out,
        output valid_out, shift_op_out, simm24_out
    );
endinterface

// File: rtl/id_stage_pipe.sv
// ARM decode stage: register file with write-through bypass, instruction decode, condition
// check, RAW hazard detection and the registered ID/EXE pipeline boundary.
module id_stage_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_CNT = 16,
    parameter bit          FWD_EN  = 1'b1
) (
    input logic            clk,
    input logic            rst,
    id_stage_pipe_if.slave bus
);
    localparam int unsigned RA_W = $clog2(REG_CNT);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpEor = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpAdd = 4'b0100;
    localparam logic [3:0] OpAdc = 4'b0101;
    localparam logic [3:0] OpSbc = 4'b0110;
    localparam logic [3:0] OpTst = 4'b1000;
    localparam logic [3:0] OpCmp = 4'b1010;
    localparam logic [3:0] OpOrr = 4'b1100;
    localparam logic [3:0] OpMov = 4'b1101;
    localparam logic [3:0] OpMvn = 4'b1111;

    localparam logic [3:0] CmdMov = 4'b0001;
    localparam logic [3:0] CmdAdd = 4'b0010;
    localparam logic [3:0] CmdAdc = 4'b0011;
    localparam logic [3:0] CmdSub = 4'b0100;
    localparam logic [3:0] CmdSbc = 4'b0101;
    localparam logic [3:0] CmdAnd = 4'b0110;
    localparam logic [3:0] CmdOrr = 4'b0111;
    localparam logic [3:0] CmdEor = 4'b1000;
    localparam logic [3:0] CmdMvn = 4'b1001;

    localparam logic [1:0] ModeDp  = 2'b00;
    localparam logic [1:0] ModeMem = 2'b01;
    localparam logic [1:0] ModeBr  = 2'b10;

    // Instruction fields
    logic [3:0]      cond;
    logic [1:0]      mode;
    logic            i_bit;
    logic [3:0]      opcode;
    logic            s_bit;
    logic [RA_W-1:0] rn_addr;
    logic [RA_W-1:0] rd_addr;
    logic [RA_W-1:0] rm_addr;
    logic [RA_W-1:0] p2_addr;
    logic            is_str;

    assign cond    = bus.instr_in[31:28];
    assign mode    = bus.instr_in[27:26];
    assign i_bit   = bus.instr_in[25];
    assign opcode  = bus.instr_in[24:21];
    assign s_bit   = bus.instr_in[20];
    assign rn_addr = RA_W'(bus.instr_in[19:16]);
    assign rd_addr = RA_W'(bus.instr_in[15:12]);
    assign rm_addr = RA_W'(bus.instr_in[3:0]);
    assign is_str  = (mode == ModeMem) && !s_bit;
    // STR reads the store data register through port 2
    assign p2_addr = is_str ? rd_addr : rm_addr;

    // Register file
    logic [DATA_W-1:0] rf_q [REG_CNT];
    logic [DATA_W-1:0] rd1_val;
    logic [DATA_W-1:0] rd2_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_CNT; i++) begin
                rf_q[i] <= '0;
            end
        end else if (bus.wb_en_in) begin
            rf_q[bus.wb_dest_in] <= bus.wb_value_in;
        end
    end

    assign rd1_val = (bus.wb_en_in && bus.wb_dest_in == rn_addr) ? bus.wb_value_in
                                                                 : rf_q[rn_addr];
    assign rd2_val = (bus.wb_en_in && bus.wb_dest_in == p2_addr) ? bus.wb_value_in
                                                                 : rf_q[p2_addr];

    // Control decode; dec_ok=0 marks encodings that turn into a bubble
    logic [3:0] dec_cmd;
    logic       dec_wb;
    logic       dec_mr;
    logic       dec_mw;
    logic       dec_b;
    logic       dec_s;
    logic       dec_ok;

    always_comb begin
        dec_cmd = '0;
        dec_wb  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_b   = 1'b0;
        dec_s   = 1'b0;
        dec_ok  = 1'b0;
        unique case (mode)
            ModeDp: begin
                dec_ok = 1'b1;
                dec_wb = 1'b1;
                dec_s  = s_bit;
                case (opcode)
                    OpMov:   dec_cmd = CmdMov;
                    OpMvn:   dec_cmd = CmdMvn;
                    OpAdd:   dec_cmd = CmdAdd;
                    OpAdc:   dec_cmd = CmdAdc;
                    OpSub:   dec_cmd = CmdSub;
                    OpSbc:   dec_cmd = CmdSbc;
                    OpAnd:   dec_cmd = CmdAnd;
                    OpOrr:   dec_cmd = CmdOrr;
                    OpEor:   dec_cmd = CmdEor;
                    OpCmp: begin
                        dec_cmd = CmdSub;
                        dec_wb  = 1'b0;
                    end
                    OpTst: begin
                        dec_cmd = CmdAnd;
                        dec_wb  = 1'b0;
                    end
                    default: begin
                        dec_ok = 1'b0;
                        dec_wb = 1'b0;
                        dec_s  = 1'b0;
                    end
                endcase
            end
            ModeMem: begin
                dec_ok  = 1'b1;
                dec_cmd = CmdAdd;
                dec_mr  = s_bit;
                dec_wb  = s_bit;
                dec_mw  = !s_bit;
            end
            ModeBr: begin
                dec_ok = 1'b1;
                dec_b  = 1'b1;
            end
            default: ;
        endcase
    end

    // Condition evaluation against NZCV
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ok;

    assign {flag_n, flag_z, flag_c, flag_v} = bus.status_in;

    always_comb begin
        cond_ok = 1'b0;
        unique case (cond)
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = !flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = !flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = !flag_n;
            4'b0110: cond_ok = flag_v;
            4'b0111: cond_ok = !flag_v;
            4'b1000: cond_ok = flag_c && !flag_z;
            4'b1001: cond_ok = !flag_c || flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ok = flag_z || (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // RAW hazard detection
    logic src1_used;
    logic two_src;
    logic exe_hit;
    logic mem_hit;
    logic stall;

    assign src1_used = !((mode == ModeDp && (opcode == OpMov || opcode == OpMvn))
                         || mode == ModeBr);
    assign two_src   = (!i_bit && mode == ModeDp) || is_str;
    assign exe_hit   = bus.exe_wb_en && ((src1_used && rn_addr == bus.exe_dest)
                                         || (two_src && p2_addr == bus.exe_dest));
    assign mem_hit   = bus.mem_wb_en && ((src1_used && rn_addr == bus.mem_dest)
                                         || (two_src && p2_addr == bus.mem_dest));

    always_comb begin
        if (FWD_EN) begin
            stall = exe_hit && bus.exe_mem_r_en;
        end else begin
            stall = exe_hit || mem_hit;
        end
    end

    // Flush overrides stall so a squashed instruction never freezes the front end
    assign bus.stall_out = stall && bus.valid_in && !bus.flush_in;

    logic issue;
    assign issue = !bus.flush_in && !bus.stall_out && bus.valid_in && cond_ok && dec_ok;

    // ID/EXE register; data fields load unconditionally, controls are bubbled
    logic [DATA_W-1:0] pc_q, val_rn_q, val_rm_q;
    logic [RA_W-1:0]   src1_q, src2_q, dest_q;
    logic [3:0]        cmd_q;
    logic              mr_q, mw_q, wb_q, b_q, s_q, imm_q, valid_q;
    logic [11:0]       shift_q;
    logic [23:0]       simm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            val_rn_q <= '0;
            val_rm_q <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            dest_q   <= '0;
            imm_q    <= 1'b0;
            shift_q  <= '0;
            simm_q   <= '0;
            cmd_q    <= '0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            wb_q     <= 1'b0;
            b_q      <= 1'b0;
            s_q      <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= bus.pc_in;
            val_rn_q <= rd1_val;
            val_rm_q <= rd2_val;
            src1_q   <= rn_addr;
            src2_q   <= p2_addr;
            dest_q   <= rd_addr;
            imm_q    <= i_bit;
            shift_q  <= bus.instr_in[11:0];
            simm_q   <= bus.instr_in[23:0];
            cmd_q    <= issue ? dec_cmd : 4'b0000;
            mr_q     <= issue && dec_mr;
            mw_q     <= issue && dec_mw;
            wb_q     <= issue && dec_wb;
            b_q      <= issue && dec_b;
            s_q      <= issue && dec_s;
            valid_q  <= issue;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.val_rn_out   = val_rn_q;
    assign bus.val_rm_out   = val_rm_q;
    assign bus.src1_out     = src1_q;
    assign bus.src2_out     = src2_q;
    assign bus.dest_out     = dest_q;
    assign bus.exe_cmd_out  = cmd_q;
    assign bus.mem_r_en_out = mr_q;
    assign bus.mem_w_en_out = mw_q;
    assign bus.wb_en_out    = wb_q;
    assign bus.b_out        = b_q;
    assign bus.s_out        = s_q;
    assign bus.imm_out      = imm_q;
    assign bus.valid_out    = valid_q;
    assign bus.shift_op_out = shift_q;
    assign bus.simm24_out   = simm_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: one instance per FWD_EN setting fed identical stimulus, checked
// against a table-driven reference model on directed steps followed by random traffic.
module tb_id_stage_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(32), .REG_CNT(16)) bus1 ();
    id_stage_pipe_if #(.DATA_W(32), .REG_CNT(16)) bus0 ();

    id_stage_pipe #(.DATA_W(32), .REG_CNT(16), .FWD_EN(1'b1)) dut_fwd (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );
    id_stage_pipe #(.DATA_W(32), .REG_CNT(16), .FWD_EN(1'b0)) dut_nofwd (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    assign bus0.instr_in     = bus1.instr_in;
    assign bus0.pc_in        = bus1.pc_in;
    assign bus0.valid_in     = bus1.valid_in;
    assign bus0.status_in    = bus1.status_in;
    assign bus0.flush_in     = bus1.flush_in;
    assign bus0.wb_en_in     = bus1.wb_en_in;
    assign bus0.wb_dest_in   = bus1.wb_dest_in;
    assign bus0.wb_value_in  = bus1.wb_value_in;
    assign bus0.exe_dest     = bus1.exe_dest;
    assign bus0.mem_dest     = bus1.mem_dest;
    assign bus0.exe_wb_en    = bus1.exe_wb_en;
    assign bus0.mem_wb_en    = bus1.mem_wb_en;
    assign bus0.exe_mem_r_en = bus1.exe_mem_r_en;

    typedef struct packed {
        logic        stall;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  dest;
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        b;
        logic        s;
        logic        imm;
        logic        valid;
        logic [11:0] shift;
        logic [23:0] simm;
    } out_t;

    out_t o1, o0;

    always_comb begin
        o1 = '{stall: bus1.stall_out, pc: bus1.pc_out, rn: bus1.val_rn_out,
               rm: bus1.val_rm_out, src1: bus1.src1_out, src2: bus1.src2_out,
               dest: bus1.dest_out, cmd: bus1.exe_cmd_out, mr: bus1.mem_r_en_out,
               mw: bus1.mem_w_en_out, wb: bus1.wb_en_out, b: bus1.b_out, s: bus1.s_out,
               imm: bus1.imm_out, valid: bus1.valid_out, shift: bus1.shift_op_out,
               simm: bus1.simm24_out};
        o0 = '{stall: bus0.stall_out, pc: bus0.pc_out, rn: bus0.val_rn_out,
               rm: bus0.val_rm_out, src1: bus0.src1_out, src2: bus0.src2_out,
               dest: bus0.dest_out, cmd: bus0.exe_cmd_out, mr: bus0.mem_r_en_out,
               mw: bus0.mem_w_en_out, wb: bus0.wb_en_out, b: bus0.b_out, s: bus0.s_out,
               imm: bus0.imm_out, valid: bus0.valid_out, shift: bus0.shift_op_out,
               simm: bus0.simm24_out};
    end

    // Reference model state
    logic [31:0] rf [16];
    // ALU command per data-processing opcode, -1 = undefined encoding
    int dp_cmd [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
    int valid_ops [11] = '{0, 1, 2, 4, 5, 6, 8, 10, 12, 13, 15};

    function automatic logic [31:0] enc(logic [3:0] c, logic i, logic [1:0] m, logic [3:0] op,
                                        logic s, logic [3:0] rn, logic [3:0] rd,
                                        logic [11:0] op2);
        return {c, m, i, op, s, rn, rd, op2};
    endfunction

    function automatic logic [31:0] read_reg(logic [3:0] a);
        if (bus1.wb_en_in && bus1.wb_dest_in == a) return bus1.wb_value_in;
        return rf[a];
    endfunction

    // ARM pairs conditions: odd codes are the complement of the even code below them
    function automatic logic cond_true(logic [3:0] c, logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic out_t model(bit fwd);
        out_t e;
        logic [31:0] ins;
        logic [1:0] m;
        logic [3:0] opc, rn, rd, p2;
        logic i, s, str, known, hit_e, hit_m, go;
        logic [3:0] srcs[$];
        ins = bus1.instr_in;
        m = ins[27:26];
        i = ins[25];
        opc = ins[24:21];
        s = ins[20];
        rn = ins[19:16];
        rd = ins[15:12];
        str = (m == 2'b01) && !s;
        p2 = str ? rd : ins[3:0];
        e = '0;
        e.pc = bus1.pc_in;
        e.rn = read_reg(rn);
        e.rm = read_reg(p2);
        e.src1 = rn;
        e.src2 = p2;
        e.dest = rd;
        e.imm = i;
        e.shift = ins[11:0];
        e.simm = ins[23:0];
        known = 1'b0;
        if (m == 2'b00 && dp_cmd[opc] >= 0) begin
            known = 1'b1;
            e.cmd = 4'(dp_cmd[opc]);
            e.wb = !(opc == 4'd8 || opc == 4'd10);
            e.s = s;
        end else if (m == 2'b01) begin
            known = 1'b1;
            e.cmd = 4'd2;
            e.mr = s;
            e.wb = s;
            e.mw = !s;
        end else if (m == 2'b10) begin
            known = 1'b1;
            e.b = 1'b1;
        end
        if (!(m == 2'b10 || (m == 2'b00 && (opc == 4'd13 || opc == 4'd15)))) srcs.push_back(rn);
        if ((!i && m == 2'b00) || str) srcs.push_back(p2);
        hit_e = 1'b0;
        hit_m = 1'b0;
        foreach (srcs[k]) begin
            if (bus1.exe_wb_en && srcs[k] == bus1.exe_dest) hit_e = 1'b1;
            if (bus1.mem_wb_en && srcs[k] == bus1.mem_dest) hit_m = 1'b1;
        end
        e.stall = bus1.valid_in && !bus1.flush_in
                  && (fwd ? (hit_e && bus1.exe_mem_r_en) : (hit_e || hit_m));
        go = !bus1.flush_in && !e.stall && bus1.valid_in && known
             && cond_true(ins[31:28], bus1.status_in);
        if (!go) begin
            {e.cmd, e.mr, e.mw, e.wb, e.b, e.s} = '0;
        end
        e.valid = go;
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string p, out_t o, out_t e, bit all);
        chk({p, ".cmd"}, 32'(o.cmd), 32'(e.cmd));
        chk({p, ".mr"}, 32'(o.mr), 32'(e.mr));
        chk({p, ".mw"}, 32'(o.mw), 32'(e.mw));
        chk({p, ".wb"}, 32'(o.wb), 32'(e.wb));
        chk({p, ".b"}, 32'(o.b), 32'(e.b));
        chk({p, ".s"}, 32'(o.s), 32'(e.s));
        chk({p, ".valid"}, 32'(o.valid), 32'(e.valid));
        if (all || e.valid) begin
            chk({p, ".pc"}, o.pc, e.pc);
            chk({p, ".rn"}, o.rn, e.rn);
            chk({p, ".rm"}, o.rm, e.rm);
            chk({p, ".src1"}, 32'(o.src1), 32'(e.src1));
            chk({p, ".src2"}, 32'(o.src2), 32'(e.src2));
            chk({p, ".dest"}, 32'(o.dest), 32'(e.dest));
            chk({p, ".imm"}, 32'(o.imm), 32'(e.imm));
            chk({p, ".shift"}, 32'(o.shift), 32'(e.shift));
            chk({p, ".simm"}, 32'(o.simm), 32'(e.simm));
        end
    endtask

    // Inputs are set after a negedge; this checks stall, clocks once, then checks the register
    task automatic cycle();
        out_t e1, e0;
        #1;
        e1 = model(1'b1);
        e0 = model(1'b0);
        chk("fwd.stall", 32'(o1.stall), 32'(e1.stall));
        chk("nofwd.stall", 32'(o0.stall), 32'(e0.stall));
        @(posedge clk);
        if (bus1.wb_en_in) rf[bus1.wb_dest_in] = bus1.wb_value_in;
        #1;
        chk_all("fwd", o1, e1, 1'b0);
        chk_all("nofwd", o0, e0, 1'b0);
    endtask

    task automatic idle_inputs();
        bus1.valid_in = 1'b0;
        bus1.flush_in = 1'b0;
        bus1.wb_en_in = 1'b0;
        bus1.exe_wb_en = 1'b0;
        bus1.mem_wb_en = 1'b0;
        bus1.exe_mem_r_en = 1'b0;
    endtask

    task automatic drive(logic [31:0] ins, logic [3:0] st);
        @(negedge clk);
        bus1.instr_in = ins;
        bus1.status_in = st;
        bus1.valid_in = 1'b1;
        bus1.pc_in = bus1.pc_in + 32'd4;
    endtask

    task automatic wb_write(logic [3:0] a, logic [31:0] v);
        @(negedge clk);
        idle_inputs();
        bus1.wb_en_in = 1'b1;
        bus1.wb_dest_in = a;
        bus1.wb_value_in = v;
        cycle();
    endtask

    task automatic rand_inputs();
        logic [3:0] c, op, rn, rd, rm;
        logic [1:0] m;
        int r;
        c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
        r = $urandom_range(0, 9);
        m = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                         : 4'(valid_ops[$urandom_range(0, 10)]);
        rn = 4'($urandom_range(0, 7));
        rd = 4'($urandom_range(0, 7));
        rm = 4'($urandom_range(0, 7));
        bus1.instr_in = enc(c, 1'($urandom), m, op, 1'($urandom), rn, rd, {8'($urandom), rm});
        bus1.pc_in = $urandom;
        bus1.status_in = 4'($urandom);
        bus1.valid_in = ($urandom_range(0, 7) != 0);
        bus1.flush_in = ($urandom_range(0, 7) == 0);
        bus1.wb_en_in = 1'($urandom);
        bus1.wb_dest_in = 4'($urandom_range(0, 7));
        bus1.wb_value_in = $urandom;
        bus1.exe_dest = 4'($urandom_range(0, 7));
        bus1.mem_dest = 4'($urandom_range(0, 7));
        bus1.exe_wb_en = 1'($urandom);
        bus1.mem_wb_en = 1'($urandom);
        bus1.exe_mem_r_en = 1'($urandom);
    endtask

    localparam logic [3:0] AL = 4'hE;

    initial begin
        out_t zero;
        zero = '0;
        foreach (rf[k]) rf[k] = '0;
        bus1.instr_in = '0;
        bus1.pc_in = '0;
        bus1.status_in = '0;
        bus1.wb_dest_in = '0;
        bus1.wb_value_in = '0;
        bus1.exe_dest = '0;
        bus1.mem_dest = '0;
        idle_inputs();
        #12 rst = 1'b0;

        // Reset mid-operation clears outputs at once and empties the register file
        wb_write(4'd3, 32'hDEAD);
        drive(enc(AL, 1'b0, 2'b00, 4'b0100, 1'b1, 4'd3, 4'd9, 12'h003), 4'h0);
        cycle();
        chk("pre_reset.valid", 32'(o1.valid), 32'd1);
        idle_inputs();
        #1 rst = 1'b1;
        #1;
        chk_all("rst.fwd", o1, zero, 1'b1);
        chk_all("rst.nofwd", o0, zero, 1'b1);
        rst = 1'b0;
        foreach (rf[k]) rf[k] = '0;
        drive(enc(AL, 1'b0, 2'b00, 4'b0100, 1'b0, 4'd3, 4'd0, 12'h003), 4'h0);
        cycle();
        chk("rst.r3", o1.rn, 32'd0);

        // ADD r1,r2,r3
        wb_write(4'd2, 32'd5);
        wb_write(4'd3, 32'd7);
        drive(enc(AL, 1'b0, 2'b00, 4'b0100, 1'b0, 4'd2, 4'd1, 12'h003), 4'h0);
        cycle();
        chk("add.cmd", 32'(o1.cmd), 32'h2);
        chk("add.wb", 32'(o1.wb), 32'd1);
        chk("add.rn", o1.rn, 32'd5);
        chk("add.rm", o1.rm, 32'd7);
        chk("add.dest", 32'(o1.dest), 32'd1);
        chk("add.valid", 32'(o1.valid), 32'd1);

        // Bypass of a same-cycle write-back
        drive(enc(AL, 1'b0, 2'b00, 4'b0100, 1'b0, 4'd2, 4'd1, 12'h003), 4'h0);
        bus1.wb_en_in = 1'b1;
        bus1.wb_dest_in = 4'd2;
        bus1.wb_value_in = 32'h1234;
        cycle();
        chk("bypass.rn", o1.rn, 32'h1234);

        // Load-use on SUB r5,r4,#1
        drive(enc(AL, 1'b1, 2'b00, 4'b0010, 1'b0, 4'd4, 4'd5, 12'h001), 4'h0);
        bus1.wb_en_in = 1'b0;
        bus1.exe_dest = 4'd4;
        bus1.exe_wb_en = 1'b1;
        bus1.exe_mem_r_en = 1'b1;
        #1;
        chk("lu.stall_fwd", 32'(o1.stall), 32'd1);
        chk("lu.stall_nofwd", 32'(o0.stall), 32'd1);
        cycle();
        chk("lu.bubble", 32'(o1.valid), 32'd0);
        @(negedge clk);
        bus1.exe_mem_r_en = 1'b0;
        #1;
        chk("lu.release", 32'(o1.stall), 32'd0);
        chk("lu.exe_raw_nofwd", 32'(o0.stall), 32'd1);
        cycle();
        chk("lu.sub_cmd", 32'(o1.cmd), 32'h4);
        @(negedge clk);
        bus1.exe_wb_en = 1'b0;
        bus1.mem_dest = 4'd4;
        bus1.mem_wb_en = 1'b1;
        #1;
        chk("mem_raw.nofwd", 32'(o0.stall), 32'd1);
        chk("mem_raw.fwd", 32'(o1.stall), 32'd0);
        cycle();
        bus1.mem_wb_en = 1'b0;

        // Condition field
        drive(enc(4'b0001, 1'b1, 2'b00, 4'b1101, 1'b0, 4'd0, 4'd0, 12'h001), 4'b0100);
        cycle();
        chk("ne_z1.valid", 32'(o1.valid), 32'd0);
        drive(enc(4'b0001, 1'b1, 2'b00, 4'b1101, 1'b0, 4'd0, 4'd0, 12'h001), 4'b0000);
        cycle();
        chk("ne_z0.cmd", 32'(o1.cmd), 32'h1);
        drive(enc(4'b1111, 1'b1, 2'b00, 4'b1101, 1'b0, 4'd0, 4'd0, 12'h001), 4'b0000);
        cycle();
        chk("nv.valid", 32'(o1.valid), 32'd0);

        // Flush beats a simultaneous load-use stall
        drive(enc(AL, 1'b1, 2'b00, 4'b0010, 1'b0, 4'd4, 4'd5, 12'h001), 4'h0);
        bus1.flush_in = 1'b1;
        bus1.exe_wb_en = 1'b1;
        bus1.exe_mem_r_en = 1'b1;
        #1;
        chk("flush.stall", 32'(o1.stall), 32'd0);
        cycle();
        chk("flush.valid", 32'(o1.valid), 32'd0);

        // STR r7,[r8]
        wb_write(4'd7, 32'hCAFE);
        drive(enc(AL, 1'b0, 2'b01, 4'b1100, 1'b0, 4'd8, 4'd7, 12'h000), 4'h0);
        cycle();
        chk("str.mw", 32'(o1.mw), 32'd1);
        chk("str.wb", 32'(o1.wb), 32'd0);
        chk("str.src2", 32'(o1.src2), 32'd7);
        chk("str.rm", o1.rm, 32'hCAFE);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rand_inputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised ARM decode stage plus ID/EXE pipeline register, for the 5-stage ARM pipeline.
- Holds the register file with write-through bypass, decodes data-processing, LDR/STR and B, and evaluates the condition field against NZCV.
- Detects RAW hazards against the EXE and MEM stages, emits stall_out, and inserts bubbles on stall, flush or condition failure.
- All decode outputs are registered, giving one cycle of latency.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_CNT, 16, number of architectural registers; address width is RA_W = clog2(REG_CNT).
- FWD_EN, 1. With 1, EXE forwarding exists downstream, so stall only on load-use. With 0, stall on any RAW match with EXE or MEM.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- instr_in  in  32  instruction from the IF/ID register.
- pc_in  in  DATA_W  PC+4 from IF/ID.
- valid_in  in  1  instr_in is a real instruction.
- status_in  in  4  NZCV flags, bit3=N, bit2=Z, bit1=C, bit0=V.
- flush_in  in  1  branch taken in EXE; discard the current ID instruction.
- wb_en_in  in  1  register file write enable.
- wb_dest_in  in  RA_W  write address.
- wb_value_in  in  DATA_W  write data.
- exe_dest, mem_dest  in  RA_W  destination registers of the EXE and MEM stages.
- exe_wb_en, mem_wb_en, exe_mem_r_en  in  1  write-back and load flags of EXE/MEM.
- stall_out  out  1  combinational; freezes the PC and IF/ID.
- pc_out, val_rn_out, val_rm_out  out  DATA_W  registered.
- src1_out, src2_out, dest_out  out  RA_W  registered; used for forwarding.
- exe_cmd_out  out  4  registered ALU command.
- mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out, valid_out  out  1  registered.
- shift_op_out  out  12  registered, instr[11:0].
- simm24_out  out  24  registered, instr[23:0].

Behaviour:
- Reset (async): all outputs 0 and every register-file entry 0. Reset mid-operation takes effect immediately.
- Fields: cond=[31:28], I=[25], mode=[27:26], opcode=[24:21], S=[20], rn=[19:16], rd=[15:12], rm=[3:0].
- Register file write: on the rising edge when wb_en_in=1.
- Register file reads: port1 reads rn. Port2 reads rd if mode=01 and S=0 (STR), else rm.
- Bypass: a read whose address equals wb_dest_in while wb_en_in=1 returns wb_value_in in the same cycle.
- Data-processing decode (mode 00), opcode -> exe_cmd, wb:
  - MOV 1101 -> 0001, wb 1; MVN 1111 -> 1001, wb 1.
  - ADD 0100 -> 0010, wb 1; ADC 0101 -> 0011, wb 1.
  - SUB 0010 -> 0100, wb 1; SBC 0110 -> 0101, wb 1.
  - AND 0000 -> 0110, wb 1; ORR 1100 -> 0111, wb 1; EOR 0001 -> 1000, wb 1.
  - CMP 1010 -> 0100, wb 0; TST 1000 -> 0110, wb 0.
  - s_out = S. Any other opcode decodes as a bubble.
- Memory decode (mode 01): exe_cmd 0010.
  - LDR (S=1): mem_r=1, wb=1.
  - STR (S=0): mem_w=1, wb=0.
- Branch decode (mode 10): b=1, all other controls 0. Mode 11 decodes as a bubble.
- Condition check:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1110 is always true; 1111 is never true.
- Source usage:
  - src1 is used unless MOV, MVN or B.
  - two_src = (!I & mode==00) | STR. src2 is used when two_src.
- Hazard: hit = used-source equals a destination whose wb_en is 1.
  - FWD_EN=1: stall_out = hit on EXE with exe_mem_r_en=1.
  - FWD_EN=0: stall_out = hit on EXE or on MEM.
  - stall_out is gated by valid_in and by !flush_in.
- Register update each rising edge, in priority order:
  - flush_in: bubble.
  - stall_out: bubble. The instruction re-decodes next cycle because IF/ID is frozen.
  - !valid_in or condition false: bubble.
  - Otherwise: load the decoded values and set valid_out=1.
- Bubble definition: exe_cmd, mem_r, mem_w, wb, b, s and valid all 0. Data fields still load; they are don't-care.
- Simultaneous stall and flush: flush wins and stall_out=0.
- A write-back to the same register that ID reads in that cycle returns the new value through the bypass.

Test Plan:
1. Reset: pulse rst between edges -> all outputs 0 immediately; reading r3 returns 0.
2. ADD r1,r2,r3 with wb r2=5 and r3=7 in prior cycles -> next edge: exe_cmd_out=0010, wb_en_out=1, val_rn_out=5, val_rm_out=7, dest_out=1, valid_out=1.
3. Bypass: wb_en_in=1, wb_dest_in=2, wb_value_in=0x1234 in the same cycle as a decode that reads r2 -> val_rn_out=0x1234.
4. Load-use, FWD_EN=1: exe_dest=4, exe_wb_en=1, exe_mem_r_en=1; ID has SUB r5,r4,#1 -> stall_out=1 and a bubble is registered. Next cycle exe_mem_r_en=0 -> stall_out=0 and SUB issues. Repeat with FWD_EN=0 and only mem_dest=4 -> stall_out=1.
5. Condition: MOVNE r0,#1 with Z=1 -> bubble. With Z=0 -> exe_cmd_out=0001. cond=1111 -> bubble.
6. Flush with a simultaneous load-use stall -> stall_out=0, bubble registered. STR r7,[r8] -> port2 reads r7, mem_w_en_out=1, wb_en_out=0.
